// File: rtl/axi_mst_wr_driver_if.sv
// Bus bundle for the write-data driver: snooped AW handshake, driven W channel, B/R readies.
interface axi_mst_wr_driver_if #(
    parameter int AXI_ID_W   = 4,
    parameter int AXI_DATA_W = 32
);
    localparam int STRB_W = AXI_DATA_W / 8;
    localparam int AL_W   = $clog2(STRB_W);

    logic                  in_awvalid;
    logic                  in_awready;
    logic [AXI_ID_W-1:0]   in_awid;
    logic [7:0]            in_awlen;
    logic [2:0]            in_awsize;
    logic [AL_W-1:0]       in_awaddr_lo;
    logic                  out_aw_full;
    logic                  out_wvalid;
    logic                  in_wready;
    logic                  out_wlast;
    logic [AXI_ID_W-1:0]   out_wid;
    logic [AXI_DATA_W-1:0] out_wdata;
    logic [STRB_W-1:0]     out_wstrb;
    logic                  in_bvalid;
    logic [1:0]            in_bresp;
    logic                  out_bready;
    logic                  out_rready;

    modport master (
        input  in_awvalid, in_awready, in_awid, in_awlen, in_awsize, in_awaddr_lo,
        output out_aw_full,
        output out_wvalid, out_wlast, out_wid, out_wdata, out_wstrb,
        input  in_wready, in_bvalid, in_bresp,
        output out_bready, out_rready
    );

    modport slave (
        output in_awvalid, in_awready, in_awid, in_awlen, in_awsize, in_awaddr_lo,
        input  out_aw_full,
        input  out_wvalid, out_wlast, out_wid, out_wdata, out_wstrb,
        output in_wready, in_bvalid, in_bresp,
        input  out_bready, out_rready
    );
endinterface

// File: rtl/axi_mst_wr_driver.sv
// AXI master write-data driver: queues snooped AW bursts, drives LFSR-patterned W beats,
// tracks B responses and throttles BREADY/RREADY with a ready LFSR.
module axi_mst_wr_driver #(
    parameter int          AXI_ID_W   = 4,
    parameter int          AXI_DATA_W = 32,
    parameter int          OSTD_NUM   = 4,
    parameter logic [31:0] LFSR_SEED  = 32'hACE12345,
    parameter logic [15:0] RDY_SEED   = 16'hBEEF
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                srst,
    axi_mst_wr_driver_if.master bus,
    input  logic [7:0]          cfg_rdy_thr,
    output logic [15:0]         st_err_cnt,
    output logic [31:0]         st_beat_cnt,
    output logic [7:0]          st_b_pend
);
    localparam int STRB_W = AXI_DATA_W / 8;
    localparam int AL_W   = $clog2(STRB_W);
    localparam int PTR_W  = $clog2(OSTD_NUM);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WORDS  = AXI_DATA_W / 32;
    // Right-shift Galois taps for x^32+x^22+x^2+x+1
    localparam logic [31:0] DLFSR_TAPS = 32'h8020_0003;

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [7:0]          len;
        logic [2:0]          size;
        logic [AL_W-1:0]     lo;
    } aw_ent_t;

    typedef struct packed {
        state_t                state;
        aw_ent_t               cur;
        logic [7:0]            bc;
        logic [PTR_W-1:0]      wr_ptr;
        logic [PTR_W-1:0]      rd_ptr;
        logic [CNT_W-1:0]      q_cnt;
        logic [31:0]           dlfsr;
        logic [15:0]           rlfsr;
        logic                  wvalid;
        logic [AXI_DATA_W-1:0] wdata;
        logic [STRB_W-1:0]     wstrb;
        logic                  bready;
        logic                  rready;
        logic [15:0]           err;
        logic [31:0]           beats;
        logic [7:0]            pend;
    } regs_t;

    function automatic logic [STRB_W-1:0] strb_calc(input logic [2:0] size,
                                                    input logic [AL_W-1:0] lo,
                                                    input logic [7:0] k);
        logic [STRB_W-1:0] st;
        int n, s, f;
        st = '1;
        if (int'(size) <= AL_W) begin
            n = 1 << size;
            s = ((int'(lo) & ~(n - 1)) + int'(k) * n) % STRB_W;
            // Only the first beat of an unaligned burst starts mid-lane
            f = (k == 8'd0) ? int'(lo) : s;
            for (int b = 0; b < STRB_W; b++) st[b] = (b >= f) && (b < s + n);
        end
        return st;
    endfunction

    function automatic logic [AXI_DATA_W-1:0] data_calc(input logic [31:0] seed,
                                                        input logic [STRB_W-1:0] st);
        logic [AXI_DATA_W-1:0] d;
        for (int i = 0; i < WORDS; i++) d[i*32 +: 32] = seed ^ (32'(i) * 32'h9E3779B9);
        for (int b = 0; b < STRB_W; b++) if (!st[b]) d[b*8 +: 8] = 8'h00;
        return d;
    endfunction

    regs_t   r;
    aw_ent_t q_mem [OSTD_NUM];
    aw_ent_t load_ent;
    logic    push, push_ok, drop, w_hs, pop, b_take, q_full, load, size_err;
    logic    [31:0] dlfsr_nx;
    logic    [STRB_W-1:0] ld_strb, adv_strb;
    logic    [AXI_DATA_W-1:0] ld_data, adv_data;
    logic    [2:0] err_inc;
    logic    [16:0] err_sum;
    logic    [15:0] err_nx;
    logic    [7:0] pend_nx;

    assign push    = bus.in_awvalid & bus.in_awready;
    assign w_hs    = bus.out_wvalid & bus.in_wready;
    assign pop     = w_hs & bus.out_wlast;
    assign b_take  = bus.in_bvalid & bus.out_bready;
    assign q_full  = (r.q_cnt == CNT_W'(OSTD_NUM));
    assign push_ok = push & (!q_full | pop);
    assign drop    = push & q_full & !pop;
    // Back-to-back bursts take the entry behind the one being popped
    assign load    = (r.state == ST_IDLE) ? (r.q_cnt != '0) : (pop && r.q_cnt > CNT_W'(1));

    assign bus.out_aw_full = q_full;
    assign bus.out_wvalid  = r.wvalid;
    assign bus.out_wlast   = r.wvalid & (r.bc == r.cur.len);
    assign bus.out_wid     = r.cur.id;
    assign bus.out_wdata   = r.wdata;
    assign bus.out_wstrb   = r.wstrb;
    assign bus.out_bready  = r.bready;
    assign bus.out_rready  = r.rready;
    assign st_err_cnt      = r.err;
    assign st_beat_cnt     = r.beats;
    assign st_b_pend       = r.pend;

    always_comb begin
        load_ent = (r.state == ST_IDLE) ? q_mem[r.rd_ptr] : q_mem[r.rd_ptr + PTR_W'(1)];
        size_err = load && (int'(load_ent.size) > AL_W);
        dlfsr_nx = w_hs ? ({1'b0, r.dlfsr[31:1]} ^ (r.dlfsr[0] ? DLFSR_TAPS : 32'h0)) : r.dlfsr;
        ld_strb  = strb_calc(load_ent.size, load_ent.lo, 8'd0);
        adv_strb = strb_calc(r.cur.size, r.cur.lo, r.bc + 8'd1);
        ld_data  = data_calc(dlfsr_nx, ld_strb);
        adv_data = data_calc(dlfsr_nx, adv_strb);
        err_inc  = 3'(drop) + 3'(size_err) + 3'(b_take && bus.in_bresp != 2'b00)
                 + 3'(b_take && !pop && r.pend == 8'd0);
        err_sum  = {1'b0, r.err} + 17'(err_inc);
        err_nx   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        pend_nx  = r.pend;
        if (pop && !b_take && r.pend != 8'hFF) pend_nx = r.pend + 8'd1;
        if (!pop && b_take && r.pend != 8'h00) pend_nx = r.pend - 8'd1;
    end

    always_ff @(posedge aclk) begin
        if (push_ok)
            q_mem[r.wr_ptr] <= '{bus.in_awid, bus.in_awlen, bus.in_awsize, bus.in_awaddr_lo};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r       <= '0;
            r.dlfsr <= LFSR_SEED;
            r.rlfsr <= RDY_SEED;
        end else if (srst) begin
            r       <= '0;
            r.dlfsr <= LFSR_SEED;
            r.rlfsr <= RDY_SEED;
        end else begin
            r.rlfsr  <= {r.rlfsr[14:0], r.rlfsr[15] ^ r.rlfsr[13] ^ r.rlfsr[12] ^ r.rlfsr[10]};
            r.bready <= (cfg_rdy_thr == 8'hFF) || (r.rlfsr[7:0] < cfg_rdy_thr);
            r.rready <= (cfg_rdy_thr == 8'hFF) || (r.rlfsr[15:8] < cfg_rdy_thr);
            r.dlfsr  <= dlfsr_nx;
            r.err    <= err_nx;
            r.pend   <= pend_nx;
            r.q_cnt  <= r.q_cnt + CNT_W'(push_ok) - CNT_W'(pop);
            if (push_ok) r.wr_ptr <= r.wr_ptr + PTR_W'(1);
            if (pop)     r.rd_ptr <= r.rd_ptr + PTR_W'(1);
            if (w_hs)    r.beats  <= r.beats + 32'd1;
            case (r.state)
                ST_IDLE: if (load) begin
                    r.state  <= ST_BURST;
                    r.cur    <= load_ent;
                    r.bc     <= 8'd0;
                    r.wvalid <= 1'b1;
                    r.wdata  <= ld_data;
                    r.wstrb  <= ld_strb;
                end
                ST_BURST: if (w_hs) begin
                    if (!bus.out_wlast) begin
                        r.bc    <= r.bc + 8'd1;
                        r.wdata <= adv_data;
                        r.wstrb <= adv_strb;
                    end else if (load) begin
                        r.cur   <= load_ent;
                        r.bc    <= 8'd0;
                        r.wdata <= ld_data;
                        r.wstrb <= ld_strb;
                    end else begin
                        r.state  <= ST_IDLE;
                        r.bc     <= 8'd0;
                        r.wvalid <= 1'b0;
                        r.wdata  <= '0;
                        r.wstrb  <= '0;
                    end
                end
                default: r.state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_mst_wr_driver.sv
// Directed bench for axi_mst_wr_driver: strobe/data table plus queue, stall, B and reset sequences.
module tb_axi_mst_wr_driver;
    localparam logic [31:0] SEED = 32'hACE12345;

    typedef struct packed {
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       lo;
        logic [3:0][3:0]  strb;
        logic             serr;
    } vec_t;

    logic        aclk = 1'b0, aresetn = 1'b0, srst = 1'b0;
    logic [7:0]  thr = 8'h00;
    logic [15:0] err32, err64;
    logic [31:0] beats32, beats64;
    logic [7:0]  pend32, pend64;
    int          errors = 0, checks = 0;

    axi_mst_wr_driver_if #(.AXI_ID_W(4), .AXI_DATA_W(32)) b32 ();
    axi_mst_wr_driver_if #(.AXI_ID_W(4), .AXI_DATA_W(64)) b64 ();

    axi_mst_wr_driver #(.AXI_ID_W(4), .AXI_DATA_W(32), .OSTD_NUM(4)) dut (
        .aclk(aclk), .aresetn(aresetn), .srst(srst), .bus(b32), .cfg_rdy_thr(thr),
        .st_err_cnt(err32), .st_beat_cnt(beats32), .st_b_pend(pend32));

    axi_mst_wr_driver #(.AXI_ID_W(4), .AXI_DATA_W(64), .OSTD_NUM(4)) dut64 (
        .aclk(aclk), .aresetn(aresetn), .srst(srst), .bus(b64), .cfg_rdy_thr(thr),
        .st_err_cnt(err64), .st_beat_cnt(beats64), .st_b_pend(pend64));

    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
    endfunction

    function automatic logic [63:0] mask_bytes(input logic [63:0] d, input logic [7:0] s);
        logic [63:0] m;
        m = d;
        for (int b = 0; b < 8; b++) if (!s[b]) m[b*8 +: 8] = 8'h00;
        return m;
    endfunction

    task automatic aw32(input logic [3:0] id, input logic [7:0] len, input logic [2:0] size,
                        input logic [1:0] lo);
        b32.in_awvalid = 1'b1; b32.in_awready = 1'b1; b32.in_awid = id;
        b32.in_awlen = len; b32.in_awsize = size; b32.in_awaddr_lo = lo;
    endtask

    task automatic pulse_srst();
        @(negedge aclk); srst = 1'b1;
        @(negedge aclk); srst = 1'b0;
    endtask

    vec_t        tv [6];
    logic [31:0] dl;
    logic [7:0]  s64 [4];
    int          exp_err, exp_beats, bad, burst, k;
    logic [8:0]  pat;
    logic [7:0]  lens [2];
    logic [31:0] prev_data;
    logic        prev_stall;

    initial begin
        tv[0] = '{8'd3, 3'd2, 2'd0, 16'hFFFF, 1'b0};
        tv[1] = '{8'd3, 3'd0, 2'd1, 16'h1842, 1'b0};
        tv[2] = '{8'd1, 3'd1, 2'd3, 16'h0038, 1'b0};
        tv[3] = '{8'd2, 3'd2, 2'd2, 16'h0FFC, 1'b0};
        tv[4] = '{8'd0, 3'd3, 2'd0, 16'h000F, 1'b1};
        tv[5] = '{8'd1, 3'd1, 2'd0, 16'h00C3, 1'b0};
        s64   = '{8'h20, 8'h40, 8'h80, 8'h01};

        b32.in_awvalid = 0; b32.in_awready = 0; b32.in_awid = 0; b32.in_awlen = 0;
        b32.in_awsize = 0; b32.in_awaddr_lo = 0; b32.in_wready = 0; b32.in_bvalid = 0;
        b32.in_bresp = 0;
        b64.in_awvalid = 0; b64.in_awready = 0; b64.in_awid = 0; b64.in_awlen = 0;
        b64.in_awsize = 0; b64.in_awaddr_lo = 0; b64.in_wready = 1; b64.in_bvalid = 0;
        b64.in_bresp = 0;

        // Reset state
        #12;
        chk("rst_wvalid", b32.out_wvalid, 0);
        chk("rst_wstrb", b32.out_wstrb, 0);
        chk("rst_wdata", b32.out_wdata, 0);
        chk("rst_readies", {b32.out_bready, b32.out_rready}, 0);
        chk("rst_counters", {err32, beats32, pend32}, 0);
        chk("rst_aw_full", b32.out_aw_full, 0);
        @(negedge aclk); aresetn = 1'b1;

        // Strobe / data table, wready held high
        dl = SEED; exp_err = 0; exp_beats = 0;
        b32.in_wready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            @(negedge aclk);
            aw32(4'(v), tv[v].len, tv[v].size, tv[v].lo);
            @(negedge aclk);
            b32.in_awvalid = 0; b32.in_awready = 0;
            chk($sformatf("tv%0d_lat_wvalid", v), b32.out_wvalid, 0);
            for (int kk = 0; kk <= int'(tv[v].len); kk++) begin
                @(negedge aclk);
                chk($sformatf("tv%0d_b%0d_wvalid", v, kk), b32.out_wvalid, 1);
                chk($sformatf("tv%0d_b%0d_wid", v, kk), b32.out_wid, 64'(v));
                chk($sformatf("tv%0d_b%0d_wstrb", v, kk), b32.out_wstrb, tv[v].strb[kk]);
                chk($sformatf("tv%0d_b%0d_wdata", v, kk), b32.out_wdata,
                    mask_bytes({32'h0, dl}, {4'h0, tv[v].strb[kk]}));
                chk($sformatf("tv%0d_b%0d_wlast", v, kk), b32.out_wlast, kk == int'(tv[v].len));
                dl = step(dl);
                exp_beats++;
            end
            exp_err += int'(tv[v].serr);
        end
        @(negedge aclk);
        chk("tv_idle_after", b32.out_wvalid, 0);
        chk("tv_beat_cnt", beats32, 64'(exp_beats));
        chk("tv_b_pend", pend32, 6);
        chk("tv_err_cnt", err32, 64'(exp_err));
        chk("tv_bready_thr0", b32.out_bready, 0);

        // 64-bit lanes, unaligned byte bursts with wrap
        dl = SEED;
        @(negedge aclk);
        b64.in_awvalid = 1; b64.in_awready = 1; b64.in_awid = 4'd9;
        b64.in_awlen = 8'd3; b64.in_awsize = 3'd0; b64.in_awaddr_lo = 3'd5;
        @(negedge aclk);
        b64.in_awvalid = 0; b64.in_awready = 0;
        for (int kk = 0; kk < 4; kk++) begin
            @(negedge aclk);
            chk($sformatf("w64_b%0d_wstrb", kk), b64.out_wstrb, s64[kk]);
            chk($sformatf("w64_b%0d_wdata", kk), b64.out_wdata,
                mask_bytes({dl ^ 32'h9E3779B9, dl}, s64[kk]));
            dl = step(dl);
        end

        // Queue full and overflow drop
        pulse_srst();
        chk("srst_counters", {err32, beats32, pend32}, 0);
        b32.in_wready = 1'b0;
        @(negedge aclk);
        aw32(4'd1, 8'd1, 3'd2, 2'd0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge aclk);
            chk($sformatf("q_full_after_%0d", i), b32.out_aw_full, i == 4);
        end
        chk("q_err_before_drop", err32, 0);
        @(negedge aclk);
        b32.in_awvalid = 0; b32.in_awready = 0;
        chk("q_err_drop", err32, 1);
        chk("q_full_hold", b32.out_aw_full, 1);

        // Two queued bursts under wready stalls
        pulse_srst();
        dl = SEED; lens = '{8'd1, 8'd2}; burst = 0; k = 0;
        pat = 9'b110010110;
        prev_stall = 1'b0; prev_data = '0;
        @(negedge aclk); aw32(4'd1, 8'd1, 3'd2, 2'd0);
        @(negedge aclk); aw32(4'd2, 8'd2, 3'd2, 2'd0);
        @(negedge aclk); b32.in_awvalid = 0; b32.in_awready = 0;
        for (int c = 0; c < 9; c++) begin
            chk($sformatf("stall_c%0d_wvalid", c), b32.out_wvalid, 1);
            chk($sformatf("stall_c%0d_wid", c), b32.out_wid, 64'(burst + 1));
            chk($sformatf("stall_c%0d_wdata", c), b32.out_wdata, 64'(dl));
            chk($sformatf("stall_c%0d_wlast", c), b32.out_wlast, k == int'(lens[burst]));
            if (prev_stall) chk($sformatf("stall_c%0d_stable", c), b32.out_wdata, 64'(prev_data));
            prev_data = b32.out_wdata;
            b32.in_wready = pat[c];
            prev_stall = !pat[c];
            if (pat[c]) begin
                dl = step(dl);
                if (k == int'(lens[burst])) begin burst++; k = 0; end
                else k++;
            end
            @(negedge aclk);
        end
        b32.in_wready = 1'b0;
        chk("stall_idle_after", b32.out_wvalid, 0);
        chk("stall_beat_cnt", beats32, 5);
        chk("stall_b_pend", pend32, 2);

        // B tracking and ready duty
        pulse_srst();
        thr = 8'hFF;
        repeat (2) @(negedge aclk);
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            if (b32.out_bready !== 1'b1 || b32.out_rready !== 1'b1) bad++;
            @(negedge aclk);
        end
        chk("rdy_const_ff", 64'(bad), 0);
        b32.in_wready = 1'b1;
        aw32(4'd3, 8'd0, 3'd2, 2'd0);
        @(negedge aclk); b32.in_awvalid = 0; b32.in_awready = 0;
        @(negedge aclk);
        chk("b_beat_wlast", b32.out_wlast, 1);
        @(negedge aclk);
        chk("b_pend_one", pend32, 1);
        b32.in_bvalid = 1; b32.in_bresp = 2'b10;
        @(negedge aclk);
        b32.in_bvalid = 0; b32.in_bresp = 2'b00;
        chk("b_slverr_pend", pend32, 0);
        chk("b_slverr_err", err32, 1);
        b32.in_bvalid = 1;
        @(negedge aclk);
        b32.in_bvalid = 0;
        chk("b_unexp_pend", pend32, 0);
        chk("b_unexp_err", err32, 2);

        // Async reset mid-burst
        aw32(4'd5, 8'd7, 3'd2, 2'd0);
        @(negedge aclk); b32.in_awvalid = 0; b32.in_awready = 0;
        repeat (3) @(negedge aclk);
        chk("ar_mid_wvalid", b32.out_wvalid, 1);
        #1 aresetn = 1'b0;
        #1;
        chk("ar_wvalid", b32.out_wvalid, 0);
        chk("ar_wlast", b32.out_wlast, 0);
        chk("ar_wstrb", b32.out_wstrb, 0);
        chk("ar_beats", beats32, 0);
        @(negedge aclk); aresetn = 1'b1;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge aclk);
            if (b32.out_wvalid !== 1'b0) bad++;
        end
        chk("ar_queue_empty", 64'(bad), 0);
        chk("ar_aw_full", b32.out_aw_full, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
